// File: rtl/bm_pkg.sv
// rtl/bm_pkg.sv - shared AHB bus-matrix encodings and the input-stage state enumeration.
package bm_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DATA = 2'd2
  } in_state_e;

  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } ctrl_t;

  function automatic logic is_active_trans(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/bm_input_hold_reg.sv
// rtl/bm_input_hold_reg.sv - address-phase hold register and live/held output mux.
module bm_input_hold_reg
  import bm_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  hold,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  ctrl_t                 ctrl,
  output logic [ADDR_WIDTH-1:0] addr_dec,
  output ctrl_t                 ctrl_dec
);

  logic [ADDR_WIDTH-1:0] addr_q;
  ctrl_t                 ctrl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      ctrl_q <= '0;
    end else if (load) begin
      addr_q <= addr;
      ctrl_q <= ctrl;
    end
  end

  assign addr_dec = hold ? addr_q : addr;
  assign ctrl_dec = hold ? ctrl_q : ctrl;

endmodule

// File: rtl/bm_input_stage.sv
// rtl/bm_input_stage.sv - per-master input stage of the 5x7 AHB bus matrix.
// Optional PEND stall counter enabled by defining BM_INPUT_STAGE_WAIT_CNT_EN.
module bm_input_stage
  import bm_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int WAIT_CNT_WIDTH = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSELS,
  input  logic [ADDR_WIDTH-1:0]     HADDRS,
  input  logic [1:0]                HTRANSS,
  input  logic                      HWRITES,
  input  logic [2:0]                HSIZES,
  input  logic [2:0]                HBURSTS,
  input  logic [3:0]                HPROTS,
  input  logic                      HMASTLOCKS,
  input  logic                      HREADYS,
  output logic                      HREADYOUTS,
  output logic                      HRESPS,
  output logic                      sel_dec,
  output logic [ADDR_WIDTH-1:0]     addr_dec,
  output logic [1:0]                trans_dec,
  output logic                      write_dec,
  output logic [2:0]                size_dec,
  output logic [2:0]                burst_dec,
  output logic [3:0]                prot_dec,
  output logic                      lock_dec,
  input  logic                      active_dec,
  input  logic                      readyout_dec,
  input  logic                      resp_dec,
  output logic [WAIT_CNT_WIDTH-1:0] wait_cnt
);

  in_state_e state, state_n;
  logic      trans_valid, grant, err_first, reg_hold, load;
  logic      data_phase, data_n, hold_n;
  ctrl_t     live_ctrl, dec_ctrl;

  assign trans_valid = HSELS & HREADYS & is_active_trans(HTRANSS);
  assign grant       = active_dec & readyout_dec;
  assign err_first   = resp_dec & ~readyout_dec;
  assign reg_hold    = (state == PEND);
  // A held transfer is never overwritten; the master is stalled until it is granted.
  assign load        = trans_valid & ~reg_hold;

  assign live_ctrl = '{trans: HTRANSS, write: HWRITES, size: HSIZES,
                       burst: HBURSTS, prot: HPROTS, lock: HMASTLOCKS};

  bm_input_hold_reg #(.ADDR_WIDTH(ADDR_WIDTH)) u_hold (
    .clk      (HCLK),
    .rst      (HRESET),
    .load     (load),
    .hold     (reg_hold),
    .addr     (HADDRS),
    .ctrl     (live_ctrl),
    .addr_dec (addr_dec),
    .ctrl_dec (dec_ctrl)
  );

  assign trans_dec = dec_ctrl.trans;
  assign write_dec = dec_ctrl.write;
  assign size_dec  = dec_ctrl.size;
  assign burst_dec = dec_ctrl.burst;
  assign prot_dec  = dec_ctrl.prot;
  assign lock_dec  = dec_ctrl.lock;
  assign sel_dec   = reg_hold | (HSELS & HTRANSS[1]);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= IDLE;
      data_phase <= 1'b0;
    end else begin
      state      <= state_n;
      data_phase <= data_n;
    end
  end

  always_comb begin
    hold_n     = reg_hold;
    data_n     = data_phase;
    HREADYOUTS = 1'b1;
    HRESPS     = HRESP_OKAY;

    // First ERROR cycle drops any pending hold so the master can abandon it.
    if (err_first)     hold_n = 1'b0;
    else if (reg_hold) hold_n = ~grant;
    else               hold_n = trans_valid & ~grant;

    if ((reg_hold | trans_valid) & grant) data_n = 1'b1;
    else if (readyout_dec)                data_n = 1'b0;

    if (hold_n)      state_n = PEND;
    else if (data_n) state_n = DATA;
    else             state_n = IDLE;

    case (state)
      PEND: HREADYOUTS = 1'b0;
      DATA: begin
        HREADYOUTS = readyout_dec;
        HRESPS     = resp_dec;
      end
      default: ;
    endcase
  end

`ifdef BM_INPUT_STAGE_WAIT_CNT_EN
  logic [WAIT_CNT_WIDTH-1:0] wait_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                  wait_q <= '0;
    else if (state_n != PEND)    wait_q <= '0;
    else if (wait_q != '1)       wait_q <= wait_q + 1'b1;
  end

  assign wait_cnt = wait_q;
`else
  assign wait_cnt = '0;
`endif

endmodule

// File: tb/tb_bm_input_stage.sv
// tb/tb_bm_input_stage.sv - directed and randomized checks of bm_input_stage against a transfer-level model.
module tb_bm_input_stage;

  localparam int AW = 32;
  localparam int WW = 8;

  logic          HCLK = 1'b0;
  logic          HRESET, HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [AW-1:0] HADDRS;
  logic [1:0]    HTRANSS;
  logic [2:0]    HSIZES, HBURSTS;
  logic [3:0]    HPROTS;
  logic          HREADYOUTS, HRESPS, sel_dec, write_dec, lock_dec;
  logic [AW-1:0] addr_dec;
  logic [1:0]    trans_dec;
  logic [2:0]    size_dec, burst_dec;
  logic [3:0]    prot_dec;
  logic          active_dec, readyout_dec, resp_dec;
  logic [WW-1:0] wait_cnt;

  bm_input_stage #(.ADDR_WIDTH(AW), .WAIT_CNT_WIDTH(WW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .sel_dec(sel_dec), .addr_dec(addr_dec), .trans_dec(trans_dec), .write_dec(write_dec),
    .size_dec(size_dec), .burst_dec(burst_dec), .prot_dec(prot_dec), .lock_dec(lock_dec),
    .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec),
    .wait_cnt(wait_cnt)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  // Transfer-level model: is a transfer parked, is a data phase outstanding, what was parked.
  bit            m_pending, m_in_data;
  logic [AW-1:0] m_addr;
  logic [13:0]   m_ctrl;
  int            m_waits;

  function automatic logic [13:0] live_ctrl();
    return {HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 0; m_in_data = 0; m_addr = '0; m_ctrl = '0; m_waits = 0;
  endtask

  task automatic look(input string tag);
    logic er, ep, es;
    int   ew;
    @(negedge HCLK);
    er = m_pending ? 1'b0 : (m_in_data ? readyout_dec : 1'b1);
    ep = (!m_pending && m_in_data) ? resp_dec : 1'b0;
    es = m_pending || (HSELS && HTRANSS[1]);
`ifdef BM_INPUT_STAGE_WAIT_CNT_EN
    ew = m_waits;
`else
    ew = 0;
`endif
    chk({tag, ".ready"}, 64'(HREADYOUTS), 64'(er));
    chk({tag, ".resp"},  64'(HRESPS), 64'(ep));
    chk({tag, ".sel"},   64'(sel_dec), 64'(es));
    chk({tag, ".addr"},  64'(addr_dec), 64'(m_pending ? m_addr : HADDRS));
    chk({tag, ".ctrl"},  64'({trans_dec, write_dec, size_dec, burst_dec, prot_dec, lock_dec}),
        64'(m_pending ? m_ctrl : live_ctrl()));
    chk({tag, ".wait"},  64'(wait_cnt), 64'(ew));
  endtask

  // Apply the transfer rules for the current inputs, then move to just after the clock edge.
  task automatic tick();
    bit accepted, granted, was_pending;
    accepted    = HSELS && HREADYS && (HTRANSS == 2'b10 || HTRANSS == 2'b11);
    granted     = active_dec && readyout_dec;
    was_pending = m_pending;
    if (!was_pending && accepted) begin
      m_addr = HADDRS;
      m_ctrl = live_ctrl();
    end
    if (granted && (was_pending || accepted)) m_in_data = 1;
    else if (readyout_dec)                    m_in_data = 0;
    if (resp_dec && !readyout_dec) m_pending = 0;
    else if (was_pending)          m_pending = !granted;
    else                           m_pending = accepted && !granted;
    m_waits = m_pending ? ((m_waits >= 255) ? 255 : m_waits + 1) : 0;
    @(posedge HCLK);
    #1;
  endtask

  task automatic master(input logic sel, input logic rdy, input logic [1:0] tr,
                        input logic [AW-1:0] a, input logic wr);
    HSELS = sel; HREADYS = rdy; HTRANSS = tr; HADDRS = a; HWRITES = wr;
    HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3; HMASTLOCKS = 1'b0;
  endtask

  task automatic slave(input logic act, input logic rdy, input logic rsp);
    active_dec = act; readyout_dec = rdy; resp_dec = rsp;
  endtask

  initial begin
    HRESET = 1'b1;
    master(0, 1, 2'b00, '0, 0);
    slave(0, 1, 0);
    model_reset();
    look("reset");
    chk("reset.ready_one", 64'(HREADYOUTS), 64'd1);
    chk("reset.sel_zero",  64'(sel_dec), 64'd0);
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // Granted NONSEQ passes straight through with no wait state.
    master(1, 1, 2'b10, 32'h2000_0000, 0);
    slave(1, 1, 0);
    look("pass");
    chk("pass.ready", 64'(HREADYOUTS), 64'd1);
    chk("pass.addr",  64'(addr_dec), 64'h2000_0000);
    tick();
    master(1, 1, 2'b00, 32'h0, 0);
    slave(0, 1, 0);
    look("pass.data");
    chk("pass.no_pend", 64'(HREADYOUTS), 64'd1);
    tick();

    // Ungranted NONSEQ parks for three cycles while the master's address moves.
    master(1, 1, 2'b10, 32'h3000_0010, 1);
    slave(0, 1, 0);
    look("pend.req");
    tick();
    for (int i = 0; i < 3; i++) begin
      master(1, 0, 2'b10, $urandom, 0);
      slave(i == 2, 1, 0);
      look("pend.wait");
      chk("pend.stall", 64'(HREADYOUTS), 64'd0);
      chk("pend.held_addr", 64'(addr_dec), 64'h3000_0010);
      chk("pend.held_write", 64'(write_dec), 64'd1);
`ifdef BM_INPUT_STAGE_WAIT_CNT_EN
      chk("pend.wait_cnt", 64'(wait_cnt), 64'(i + 1));
`endif
      tick();
    end
    master(1, 1, 2'b00, 32'h0, 0);
    slave(0, 1, 0);
    look("pend.done");
    chk("pend.done_ready", 64'(HREADYOUTS), 64'd1);
    chk("pend.done_wait", 64'(wait_cnt), 64'd0);
    tick();

    // Granted write with a two-cycle slave wait.
    master(1, 1, 2'b10, 32'h4000_0004, 1);
    slave(1, 1, 0);
    look("wr.addr");
    tick();
    master(1, 0, 2'b00, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      slave(0, i == 2, 0);
      look("wr.data");
      chk("wr.mirror", 64'(HREADYOUTS), 64'(i == 2));
      tick();
    end

    // Two-cycle ERROR cancels the next transfer offered during the first cycle.
    master(1, 1, 2'b10, 32'h5000_0000, 0);
    slave(1, 1, 0);
    look("err.addr");
    tick();
    master(1, 1, 2'b10, 32'h5000_0004, 0);
    slave(0, 0, 1);
    look("err.first");
    chk("err.first_resp",  64'(HRESPS), 64'd1);
    chk("err.first_ready", 64'(HREADYOUTS), 64'd0);
    tick();
    master(1, 1, 2'b00, 32'h0, 0);
    slave(0, 1, 1);
    look("err.second");
    chk("err.second_resp",  64'(HRESPS), 64'd1);
    chk("err.second_ready", 64'(HREADYOUTS), 64'd1);
    chk("err.hold_cleared", 64'(sel_dec), 64'd0);
    tick();
    slave(0, 0, 0);
    look("err.idle");
    chk("err.idle_ready", 64'(HREADYOUTS), 64'd1);
    chk("err.idle_resp",  64'(HRESPS), 64'd0);
    tick();

    // BUSY is acknowledged at once and never parked.
    master(1, 1, 2'b01, 32'h6000_0000, 0);
    slave(0, 0, 0);
    look("busy");
    chk("busy.ready", 64'(HREADYOUTS), 64'd1);
    chk("busy.resp",  64'(HRESPS), 64'd0);
    tick();
    master(1, 1, 2'b00, 32'h0, 0);
    look("busy.after");
    chk("busy.not_held", 64'(sel_dec), 64'd0);
    tick();

    // Reset while a transfer is parked discards it.
    master(1, 1, 2'b10, 32'h7000_0000, 0);
    slave(0, 1, 0);
    look("rst.req");
    tick();
    master(1, 0, 2'b00, 32'h0, 0);
    look("rst.pend");
    chk("rst.pend_stall", 64'(HREADYOUTS), 64'd0);
    @(posedge HCLK); #1;
    m_waits = (m_waits >= 255) ? 255 : m_waits + 1;
    HRESET = 1'b1;
    #2;
    chk("rst.async_ready", 64'(HREADYOUTS), 64'd1);
    chk("rst.async_sel",   64'(sel_dec), 64'd0);
    chk("rst.async_wait",  64'(wait_cnt), 64'd0);
    model_reset();
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    look("rst.after");
    chk("rst.after_ready", 64'(HREADYOUTS), 64'd1);
    tick();

    // Long stall drives the wait counter into saturation.
    master(1, 1, 2'b10, 32'h8000_0000, 0);
    slave(0, 1, 0);
    look("sat.req");
    tick();
    master(1, 0, 2'b10, 32'h0, 0);
    for (int i = 0; i < 260; i++) begin
      look("sat.wait");
      tick();
    end
`ifdef BM_INPUT_STAGE_WAIT_CNT_EN
    chk("sat.all_ones", 64'(wait_cnt), 64'd255);
`else
    chk("sat.const_zero", 64'(wait_cnt), 64'd0);
`endif
    slave(1, 1, 0);
    look("sat.grant");
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      HSELS        = ($urandom_range(0, 3) != 0);
      HREADYS      = $urandom_range(0, 1);
      HTRANSS      = 2'($urandom_range(0, 3));
      HADDRS       = $urandom;
      HWRITES      = $urandom_range(0, 1);
      HSIZES       = 3'($urandom_range(0, 7));
      HBURSTS      = 3'($urandom_range(0, 7));
      HPROTS       = 4'($urandom_range(0, 15));
      HMASTLOCKS   = $urandom_range(0, 1);
      active_dec   = $urandom_range(0, 1);
      readyout_dec = ($urandom_range(0, 3) != 0);
      resp_dec     = ($urandom_range(0, 7) == 0);
      look("rand");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
